csr_access_unit: RTL
====================

# csr_access_unit

Initiator side of the control/status register interface: executes decoded Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) by sequencing a read, a modify and a write against the CSR register file. It sits between the execute stage and the CSR register file. It presents the file's read and write ports as a posedge-clocked handshake sequence, and returns the old CSR value for write-back to rd.

## Interface
Parameters:
- none; CSR indices and funct3 encodings come from `Defines.v`.

Ports:
- clk  in  1  system clock; the unit is posedge-triggered.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; accepted only when busy=0.
- funct3  in  3  Zicsr funct3 field.
- csr_index  in  12  target CSR address.
- rs1_value  in  32  register source operand.
- uimm  in  5  immediate source (rs1 field) for the immediate forms.
- rs1_is_zero  in  1  rs1 field / uimm field equals 0.
- rd_is_zero  in  1  rd field equals 0.
- busy  out  1  high from the accepting cycle until done.
- done  out  1  one-cycle completion pulse.
- rd_data  out  32  old CSR value; valid while done=1.
- rd_write_enable  out  1  write-back request; qualified by done.
- read_enable_csr  out  1  to CSR file read port.
- csr_read_index  out  12  to CSR file read port.
- csr_read_data  in  32  from CSR file; undriven (z) when not enabled.
- write_enable_csr  out  1  to CSR file write port.
- csr_write_index  out  12  to CSR file write port.
- csr_write_data  out  32  to CSR file write port.
- illegal  out  1  present only with the configuration macro; see Configuration.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + start:
  - Latch funct3, csr_index, the source operand, rd_is_zero and rs1_is_zero.
  - Source operand: funct3[2] ? {27'b0, uimm} : rs1_value.
- do_read = !(funct3 is CSRRW/CSRRWI and rd_is_zero).
- do_write = funct3 is CSRRW/CSRRWI, or rs1_is_zero=0.
- Transitions:
  - From IDLE on start: go to READ if do_read, else WRITE.
  - READ → WRITE if do_write, else DONE.
  - WRITE → DONE.
  - DONE → IDLE.
- READ: read_enable_csr=1, csr_read_index=latched index. The posedge ending READ captures csr_read_data into old_value.
- WRITE: write_enable_csr=1, csr_write_index=latched index. csr_write_data is computed as follows:
  - CSRRW(I): src.
  - CSRRS(I): old_value | src.
  - CSRRC(I): old_value & ~src.
  - If READ was skipped, old_value=0, and only CSRRW(I) can reach this path.
- DONE:
  - done=1 and rd_data=old_value.
  - rd_write_enable = do_read & !rd_is_zero.
- funct3 000 or 100: go IDLE→DONE with no CSR access; rd_write_enable=0.
- start while busy=1: ignored; no queueing.

## Timing
- Reset: state IDLE. busy, done, rd_write_enable, read_enable_csr and write_enable_csr are 0. rd_data, both indices and csr_write_data are 0; illegal=0.
- CSR-port outputs are registered, changing only on posedge. The CSR file writes on negedge, mid-way through the WRITE cycle.
- Latency from the start posedge to the done cycle:
  - 3 cycles with read and write.
  - 2 cycles with only one of them.
  - 1 cycle for invalid funct3.
- busy is high in READ, WRITE and DONE. A new start is accepted in the cycle after DONE.
- Reset asserted mid-operation: return to IDLE immediately. A pending WRITE is not issued, and no done pulse occurs.
- csr_read_data is sampled only in READ; z/x on the bus outside READ never propagates.

## Configuration
- CSR_ACCESS_ILLEGAL_CHECK_EN defined:
  - A write to a read-only CSR (csr_index[11:10]==2'b11) with do_write=1 skips WRITE.
  - The DONE cycle then raises illegal=1 with rd_write_enable=0.
  - Invalid funct3 also raises illegal in DONE.
- Undefined: the illegal port is absent, and such writes are issued to the file normally.

## Structure
- Shared package / `Defines.v`: funct3 encodings (CSRRW..CSRRCI), state encoding, CSR index constants, and the read-only address mask.
- Sub-module csr_modify_logic: combinational; takes funct3, old_value and src, and produces the new value.

## Test plan
- Write then read back: CSRRW to alucsr with rs1_value=0x0000_00A5 and rd≠0, after reset.
  - Write port shows 0xA5 in WRITE.
  - done at cycle 3 with rd_data=0, rd_write_enable=1.
  - A following CSRRS with rs1=0 returns 0xA5 with no WRITE cycle (latency 2).
- Set and clear bits: mulcsr=0xF0, CSRRSI with uimm=0x0F → write 0xFF, rd_data=0xF0. Then CSRRC with rs1_value=0x3C → write 0xC3.
- CSRRWI to divcsr with rd=x0: read_enable_csr never asserts, write 0x1F, done at cycle 2, rd_write_enable=0.
- start pulsed while busy: ignored, exactly one transaction. Reset during WRITE: write_enable_csr drops asynchronously and the CSR keeps its old value.
- Invalid funct3 000: done at cycle 1, no CSR enables asserted, rd_write_enable=0. With CSR_ACCESS_ILLEGAL_CHECK_EN, illegal=1.
- With CSR_ACCESS_ILLEGAL_CHECK_EN, CSRRW to mcycle (0xB00) is writable and passes. CSRRW to 0xC00 raises illegal=1 and write_enable_csr stays 0.

Source files
------------

// File: rtl/csr_access_unit_pkg.sv
// rtl/csr_access_unit_pkg.sv - Shared Zicsr encodings, FSM states and CSR address constants
//
// Purpose: funct3 encodings for CSRRW..CSRRCI, the access FSM state type,
//          CSR index constants and the read-only address mask/helpers.
package csr_access_unit_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Low two funct3 bits select the operation; bit 2 selects the immediate form.
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] CSR_ALUCSR = 12'h7C0;
  localparam logic [11:0] CSR_MULCSR = 12'h7C1;
  localparam logic [11:0] CSR_DIVCSR = 12'h7C2;
  localparam logic [11:0] CSR_MCYCLE = 12'hB00;

  // CSR addresses with [11:10] == 2'b11 are read-only.
  localparam logic [11:0] CSR_RO_MASK = 12'hC00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic f3_is_valid(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

  function automatic logic f3_is_rw(input logic [2:0] f3);
    return f3[1:0] == OP_RW;
  endfunction

  function automatic logic is_csr_ro(input logic [11:0] idx);
    return (idx & CSR_RO_MASK) == CSR_RO_MASK;
  endfunction

endpackage

// File: rtl/csr_modify_logic.sv
// rtl/csr_modify_logic.sv - Combinational read-modify step for Zicsr operations
//
// Ports:
//   i_op        [1:0]  funct3[1:0] (01 write, 10 set, 11 clear)
//   i_old_value [31:0] value read from the CSR (0 when the read was skipped)
//   i_src       [31:0] rs1 value or zero-extended uimm
//   o_new_value [31:0] value to write back to the CSR
module csr_modify_logic
  import csr_access_unit_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [31:0] i_old_value,
  input  logic [31:0] i_src,
  output logic [31:0] o_new_value
);

  always_comb begin
    o_new_value = i_src;
    case (i_op)
      OP_RW:   o_new_value = i_src;
      OP_RS:   o_new_value = i_old_value | i_src;
      OP_RC:   o_new_value = i_old_value & ~i_src;
      default: o_new_value = i_old_value;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - Zicsr initiator: read / modify / write sequencing against the CSR file
//
// Optional feature macro: CSR_ACCESS_ILLEGAL_CHECK_EN (adds the illegal output,
// suppresses writes to read-only CSRs and flags invalid funct3).
//
// Ports:
//   clk, reset             posedge clock, asynchronous active-high reset
//   start                  request pulse, accepted only when idle
//   funct3, csr_index      decoded instruction fields
//   rs1_value, uimm        register / immediate source operand
//   rs1_is_zero, rd_is_zero  rs1/uimm field and rd field equal zero
//   busy, done             busy from acceptance through DONE; one-cycle done pulse
//   rd_data, rd_write_enable  old CSR value and write-back request (valid with done)
//   read_enable_csr, csr_read_index, csr_read_data      CSR file read port
//   write_enable_csr, csr_write_index, csr_write_data   CSR file write port
//   illegal                (macro only) access fault reported in the DONE cycle
module csr_access_unit
  import csr_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_index,
  input  logic [31:0] rs1_value,
  input  logic [4:0]  uimm,
  input  logic        rs1_is_zero,
  input  logic        rd_is_zero,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        rd_write_enable,
  output logic        read_enable_csr,
  output logic [11:0] csr_read_index,
  input  logic [31:0] csr_read_data,
  output logic        write_enable_csr,
  output logic [11:0] csr_write_index,
  output logic [31:0] csr_write_data
`ifdef CSR_ACCESS_ILLEGAL_CHECK_EN
  ,
  output logic        illegal
`endif
);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_op;
  logic [11:0] r_index;
  logic [31:0] r_src;
  logic [31:0] r_old_value;
  logic        r_do_read;
  logic        r_do_write;
  logic        r_rd_is_zero;
  logic        r_read_enable;
  logic        r_write_enable;
  logic [11:0] r_read_index;
  logic [11:0] r_write_index;
  logic [31:0] r_write_data;
`ifdef CSR_ACCESS_ILLEGAL_CHECK_EN
  logic        r_illegal;
`endif

  logic        w_accept;
  logic        w_valid_in;
  logic        w_is_rw_in;
  logic        w_do_read_in;
  logic        w_do_write_raw_in;
  logic        w_ro_block_in;
  logic        w_do_write_in;
  logic [31:0] w_src_in;
  logic [1:0]  w_op_next;
  logic [11:0] w_index_next;
  logic [31:0] w_src_next;
  logic [31:0] w_old_next;
  logic [31:0] w_new_value;

  assign w_accept          = start && (r_state == ST_IDLE);
  assign w_valid_in        = f3_is_valid(funct3);
  assign w_is_rw_in        = f3_is_rw(funct3);
  assign w_do_read_in      = w_valid_in && !(w_is_rw_in && rd_is_zero);
  assign w_do_write_raw_in = w_valid_in && (w_is_rw_in || !rs1_is_zero);
`ifdef CSR_ACCESS_ILLEGAL_CHECK_EN
  assign w_ro_block_in     = is_csr_ro(csr_index) && w_do_write_raw_in;
`else
  assign w_ro_block_in     = 1'b0;
`endif
  assign w_do_write_in     = w_do_write_raw_in && !w_ro_block_in;
  assign w_src_in          = funct3[2] ? {27'b0, uimm} : rs1_value;

  // The CSR port registers load on the same edge that enters READ/WRITE, so
  // they must see the operands being latched this edge, not the stale copies.
  assign w_op_next    = w_accept ? funct3[1:0] : r_op;
  assign w_index_next = w_accept ? csr_index : r_index;
  assign w_src_next   = w_accept ? w_src_in : r_src;
  // Leaving READ, the write data is built from the bus value captured on this
  // same edge; the bus is only looked at while in READ.
  assign w_old_next   = (r_state == ST_READ) ? csr_read_data
                      : (w_accept ? 32'b0 : r_old_value);

  csr_modify_logic u_modify (
    .i_op        (w_op_next),
    .i_old_value (w_old_next),
    .i_src       (w_src_next),
    .o_new_value (w_new_value)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_do_read_in)       w_next_state = ST_READ;
          else if (w_do_write_in) w_next_state = ST_WRITE;
          else                    w_next_state = ST_DONE;
        end
      end
      ST_READ:  w_next_state = r_do_write ? ST_WRITE : ST_DONE;
      ST_WRITE: w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op           <= 2'b0;
      r_index        <= 12'b0;
      r_src          <= 32'b0;
      r_old_value    <= 32'b0;
      r_do_read      <= 1'b0;
      r_do_write     <= 1'b0;
      r_rd_is_zero   <= 1'b0;
      r_read_enable  <= 1'b0;
      r_write_enable <= 1'b0;
      r_read_index   <= 12'b0;
      r_write_index  <= 12'b0;
      r_write_data   <= 32'b0;
`ifdef CSR_ACCESS_ILLEGAL_CHECK_EN
      r_illegal      <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_op         <= funct3[1:0];
        r_index      <= csr_index;
        r_src        <= w_src_in;
        r_old_value  <= 32'b0;
        r_do_read    <= w_do_read_in;
        r_do_write   <= w_do_write_in;
        r_rd_is_zero <= rd_is_zero;
`ifdef CSR_ACCESS_ILLEGAL_CHECK_EN
        r_illegal    <= !w_valid_in || w_ro_block_in;
`endif
      end
      if (r_state == ST_READ) r_old_value <= csr_read_data;

      r_read_enable  <= (w_next_state == ST_READ);
      r_write_enable <= (w_next_state == ST_WRITE);
      if (w_next_state == ST_READ) r_read_index <= w_index_next;
      if (w_next_state == ST_WRITE) begin
        r_write_index <= w_index_next;
        r_write_data  <= w_new_value;
      end
    end
  end

  assign busy             = (r_state != ST_IDLE);
  assign done             = (r_state == ST_DONE);
  assign rd_data          = r_old_value;
  assign read_enable_csr  = r_read_enable;
  assign csr_read_index   = r_read_index;
  assign write_enable_csr = r_write_enable;
  assign csr_write_index  = r_write_index;
  assign csr_write_data   = r_write_data;
`ifdef CSR_ACCESS_ILLEGAL_CHECK_EN
  assign illegal          = (r_state == ST_DONE) && r_illegal;
  assign rd_write_enable  = (r_state == ST_DONE) && r_do_read && !r_rd_is_zero && !r_illegal;
`else
  assign rd_write_enable  = (r_state == ST_DONE) && r_do_read && !r_rd_is_zero;
`endif

endmodule
